dcache_write_buffer: RTL and testbench

- FIFO write buffer between the data cache and the AXI bridge's data write port.
- Queues dirty-line write-backs (type 3'b100) and uncached stores (types 3'b000/001/010) from the dcache.
- Issues queued entries in order to the bridge over data_wr_req/data_wr_rdy, so dcache refills need not wait behind write-backs.
- Provides a line-address hazard check so the dcache never refills a line that still has a pending write.

---
 rtl/dcache_write_buffer.sv | 169 ++++++++++++++++
 tb/tb_dcache_write_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
//
// In-order FIFO write buffer between the data cache and the AXI bridge's data
// write port. Dirty-line write-backs (type 3'b100) and uncached stores
// (types 3'b000/001/010) are queued here, so a refill does not have to wait
// for a write-back to finish. A line-address hazard check tells the dcache
// whether a miss address still has a write pending.
//
// Optional feature: define WBUF_MERGE_EN to fold a write into the youngest
// queued entry when type and address match exactly.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready dcache write handshake; transfer when both are high
//   in_type           3'b100 = full line, otherwise the AXI size code
//   in_addr           write address (line-aligned for lines)
//   in_wstrb          byte strobes (4'hf for lines)
//   in_data           write data, word 0 in [31:0]
//   wr_req/wr_rdy     request/ready handshake to the bridge data write port
//   wr_type/addr/wstrb/data  head entry presented to the bridge
//   bridge_empty      bridge has no write outstanding
//   query_addr        dcache miss address to check
//   query_hit         a pending write targets the same line
//   all_empty         buffer and bridge both drained

module dcache_write_buffer #(
  parameter int DEPTH        = 4,
  parameter int LINE_WIDTH   = 128,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_type,
  input  logic [31:0]           in_addr,
  input  logic [3:0]            in_wstrb,
  input  logic [LINE_WIDTH-1:0] in_data,
  output logic                  wr_req,
  output logic [2:0]            wr_type,
  output logic [31:0]           wr_addr,
  output logic [3:0]            wr_wstrb,
  output logic [LINE_WIDTH-1:0] wr_data,
  input  logic                  wr_rdy,
  input  logic                  bridge_empty,
  input  logic [31:0]           query_addr,
  output logic                  query_hit,
  output logic                  all_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [2:0]            type_mem  [DEPTH];
  logic [31:0]           addr_mem  [DEPTH];
  logic [3:0]            wstrb_mem [DEPTH];
  logic [LINE_WIDTH-1:0] data_mem  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             pop;
  logic             push;
  logic             merge_ok;
  logic [DEPTH-1:0] entry_valid;

  // Only the line part of the query address takes part in the hazard check.
  logic query_offset_unused;
  assign query_offset_unused = ^query_addr[OFFSET_WIDTH-1:0];

  assign wr_req = (count != '0);
  assign pop    = wr_req && wr_rdy;

`ifdef WBUF_MERGE_EN
  logic [PTR_W-1:0] youngest;
  assign youngest = tail - PTR_W'(1);

  // The youngest entry is only safe to update if the bridge is not taking it
  // this very cycle; with a single entry, head and youngest are the same slot.
  assign merge_ok = in_valid && (count != '0)
                    && !(pop && (count == (PTR_W+1)'(1)))
                    && (type_mem[youngest] == in_type)
                    && (addr_mem[youngest] == in_addr);
`else
  assign merge_ok = 1'b0;
`endif

  // A pop in the same cycle deliberately does not free a slot for a push.
  assign in_ready = (count < FULL_COUNT) || merge_ok;
  assign push     = in_valid && in_ready && !merge_ok;

  // Entry storage has no reset; validity comes from head/count only.
  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[tail]  <= in_type;
      addr_mem[tail]  <= in_addr;
      wstrb_mem[tail] <= in_wstrb;
      data_mem[tail]  <= in_data;
    end
`ifdef WBUF_MERGE_EN
    else if (merge_ok) begin
      if (in_type == 3'b100) begin
        data_mem[youngest] <= in_data;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (in_wstrb[b]) begin
            data_mem[youngest][8*b +: 8] <= in_data[8*b +: 8];
          end
        end
        wstrb_mem[youngest] <= wstrb_mem[youngest] | in_wstrb;
      end
    end
`endif
  end

  // Pointers wrap naturally at DEPTH; count carries the extra full bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign wr_type  = type_mem[head];
  assign wr_addr  = addr_mem[head];
  assign wr_wstrb = wstrb_mem[head];
  assign wr_data  = data_mem[head];

  // A slot is live when its distance from head is below count.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - head)} < count);
    end
  end

  // The head entry being popped is still live here, and an accepted push is
  // included, so the check errs on the side of reporting a hazard.
  always_comb begin
    query_hit = in_valid && in_ready
                && (in_addr[31:OFFSET_WIDTH] == query_addr[31:OFFSET_WIDTH]);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]
          && (addr_mem[i][31:OFFSET_WIDTH] == query_addr[31:OFFSET_WIDTH])) begin
        query_hit = 1'b1;
      end
    end
  end

  assign all_empty = (count == '0) && bridge_empty;

  // Types 3'b011 and 3'b101..3'b111 are stored unchanged but never expected.
  legal_type_check: assert property (@(posedge clk) disable iff (reset)
    (in_valid && in_ready) |-> (in_type inside {3'b000, 3'b001, 3'b010, 3'b100}));

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer
//
// Self-checking bench for dcache_write_buffer (DEPTH=4, 128-bit lines).
// A table of single-cycle vectors with constant expectations covers the
// directed cases; a queue-based scoreboard, updated at every negative edge,
// checks the fields of every popped entry and the handshake/hazard outputs.
// Build with WBUF_MERGE_EN defined to exercise the merge behaviour.

module tb_dcache_write_buffer;

  localparam int DEPTH = 4;
  localparam int LW    = 128;
  localparam int OW    = 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_type;
  logic [31:0]   in_addr;
  logic [3:0]    in_wstrb;
  logic [LW-1:0] in_data;
  logic          wr_req;
  logic [2:0]    wr_type;
  logic [31:0]   wr_addr;
  logic [3:0]    wr_wstrb;
  logic [LW-1:0] wr_data;
  logic          wr_rdy;
  logic          bridge_empty;
  logic [31:0]   query_addr;
  logic          query_hit;
  logic          all_empty;

  dcache_write_buffer #(.DEPTH(DEPTH), .LINE_WIDTH(LW), .OFFSET_WIDTH(OW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_addr(in_addr), .in_wstrb(in_wstrb), .in_data(in_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
    .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .bridge_empty(bridge_empty), .query_addr(query_addr),
    .query_hit(query_hit), .all_empty(all_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WBUF_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  typedef struct {
    logic          valid;
    logic [2:0]    typ;
    logic [31:0]   addr;
    logic [3:0]    wstrb;
    logic [LW-1:0] data;
    logic          rdy;
    logic          be;
    logic [31:0]   qaddr;
    logic          exp_ready;
    logic          exp_req;
    logic          exp_hit;
    logic          exp_empty;
  } vec_t;

  typedef struct {
    logic [2:0]    typ;
    logic [31:0]   addr;
    logic [3:0]    wstrb;
    logic [LW-1:0] data;
  } sb_t;

  int vectors_applied = 0;
  int miscompares     = 0;

  sb_t  sb[$];
  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [LW-1:0] act,
                             input logic [LW-1:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    in_valid     = v.valid;
    in_type      = v.typ;
    in_addr      = v.addr;
    in_wstrb     = v.wstrb;
    in_data      = v.data;
    wr_rdy       = v.rdy;
    bridge_empty = v.be;
    query_addr   = v.qaddr;
  endtask

  function automatic vec_t mk(logic v, logic [2:0] t, logic [31:0] a,
                              logic [3:0] s, logic [LW-1:0] d, logic r,
                              logic b, logic [31:0] q, logic er, logic eq,
                              logic eh, logic ee);
    vec_t x;
    x.valid = v; x.typ = t; x.addr = a; x.wstrb = s; x.data = d;
    x.rdy = r; x.be = b; x.qaddr = q;
    x.exp_ready = er; x.exp_req = eq; x.exp_hit = eh; x.exp_empty = ee;
    return x;
  endfunction

  // Scoreboard: model of the queue, updated once per cycle just before the
  // active edge, using only the bench's own stimulus.
  logic exp_req_m, exp_pop_m, exp_merge_m, exp_ready_m, exp_hit_m;
  sb_t  new_e;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      exp_req_m   = (sb.size() != 0);
      exp_pop_m   = exp_req_m && wr_rdy;
      exp_merge_m = 1'b0;
      if (MERGE && in_valid && sb.size() != 0
          && !(exp_pop_m && sb.size() == 1)
          && sb[$].typ == in_type && sb[$].addr == in_addr) begin
        exp_merge_m = 1'b1;
      end
      exp_ready_m = (sb.size() < DEPTH) || exp_merge_m;
      exp_hit_m   = in_valid && exp_ready_m && (in_addr[31:OW] == query_addr[31:OW]);
      foreach (sb[i]) begin
        if (sb[i].addr[31:OW] == query_addr[31:OW]) exp_hit_m = 1'b1;
      end

      checkOutput("sb_wr_req", LW'(wr_req), LW'(exp_req_m));
      checkOutput("sb_in_ready", LW'(in_ready), LW'(exp_ready_m));
      checkOutput("sb_query_hit", LW'(query_hit), LW'(exp_hit_m));
      checkOutput("sb_all_empty", LW'(all_empty), LW'(sb.size() == 0 && bridge_empty));

      if (exp_pop_m) begin
        checkOutput("sb_wr_type", LW'(wr_type), LW'(sb[0].typ));
        checkOutput("sb_wr_addr", LW'(wr_addr), LW'(sb[0].addr));
        checkOutput("sb_wr_wstrb", LW'(wr_wstrb), LW'(sb[0].wstrb));
        checkOutput("sb_wr_data", wr_data, sb[0].data);
        void'(sb.pop_front());
      end

      if (in_valid && exp_merge_m) begin
        if (in_type == 3'b100) begin
          sb[$].data = in_data;
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (in_wstrb[b]) sb[$].data[8*b +: 8] = in_data[8*b +: 8];
          end
          sb[$].wstrb = sb[$].wstrb | in_wstrb;
        end
      end else if (in_valid && exp_ready_m) begin
        new_e.typ = in_type; new_e.addr = in_addr;
        new_e.wstrb = in_wstrb; new_e.data = in_data;
        sb.push_back(new_e);
      end
    end
  end

  localparam logic [LW-1:0] LD  = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [LW-1:0] LD2 = 128'h55aa55aa_11223344_99887766_deadbeef;

  logic [2:0]  rnd_type;
  logic [31:0] rnd_addr;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_type = 3'b000; in_addr = '0;
    in_wstrb = '0; in_data = '0; wr_rdy = 1'b0; bridge_empty = 1'b1;
    query_addr = '0;

    //          v  type    addr          wstrb  data         rdy be  qaddr        rdy req hit emp
    vecs[0]  = mk(0, 3'b000, 32'h0,        4'h0, '0,          1, 1, 32'h1c000040, 1, 0, 0, 1);
    vecs[1]  = mk(1, 3'b100, 32'h1c000040, 4'hf, LD,          1, 1, 32'h1c00004c, 1, 0, 1, 1);
    vecs[2]  = mk(0, 3'b000, 32'h0,        4'h0, '0,          1, 0, 32'h1c000040, 1, 1, 1, 0);
    vecs[3]  = mk(0, 3'b000, 32'h0,        4'h0, '0,          1, 1, 32'h1c000040, 1, 0, 0, 1);
    vecs[4]  = mk(1, 3'b010, 32'h1faf0000, 4'hf, 128'h11111111, 0, 1, 32'h1c000050, 1, 0, 0, 1);
    vecs[5]  = mk(1, 3'b100, 32'h1c000040, 4'hf, LD2,         0, 1, 32'h1c00004c, 1, 1, 1, 0);
    vecs[6]  = mk(1, 3'b000, 32'h1faf0101, 4'h2, 128'h2200,   0, 1, 32'h1c000050, 1, 1, 0, 0);
    vecs[7]  = mk(1, 3'b001, 32'h1faf0202, 4'hc, 128'h33330000, 0, 1, 32'h1c000048, 1, 1, 1, 0);
    vecs[8]  = mk(1, 3'b100, 32'h1c000050, 4'hf, LD,          0, 1, 32'h1c000050, 0, 1, 0, 0);
    vecs[9]  = mk(1, 3'b100, 32'h1c000050, 4'hf, LD,          1, 1, 32'h1c000050, 0, 1, 0, 0);
    vecs[10] = mk(1, 3'b100, 32'h1c000050, 4'hf, LD,          0, 1, 32'h1c000050, 1, 1, 1, 0);
    vecs[11] = mk(0, 3'b000, 32'h0,        4'h0, '0,          0, 1, 32'h1faf0000, 0, 1, 0, 0);
    vecs[12] = mk(0, 3'b000, 32'h0,        4'h0, '0,          1, 1, 32'h00000000, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int k = 0; k < 13; k++) begin
      applyStimulus(vecs[k]);
      @(negedge clk);
      checkOutput($sformatf("v%0d_in_ready", k), LW'(in_ready), LW'(vecs[k].exp_ready));
      checkOutput($sformatf("v%0d_wr_req", k), LW'(wr_req), LW'(vecs[k].exp_req));
      checkOutput($sformatf("v%0d_query_hit", k), LW'(query_hit), LW'(vecs[k].exp_hit));
      checkOutput($sformatf("v%0d_all_empty", k), LW'(all_empty), LW'(vecs[k].exp_empty));
    end

    // Reset with three entries queued: everything is discarded.
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; wr_rdy = 1'b0; query_addr = 32'h1faf0100;
    @(posedge clk); #1;
    reset = 1'b0; bridge_empty = 1'b0;
    @(negedge clk);
    checkOutput("rst_wr_req", LW'(wr_req), LW'(0));
    checkOutput("rst_in_ready", LW'(in_ready), LW'(1));
    checkOutput("rst_query_hit", LW'(query_hit), LW'(0));
    checkOutput("rst_all_empty_bridge_busy", LW'(all_empty), LW'(0));
    @(posedge clk); #1;
    bridge_empty = 1'b1;
    @(negedge clk);
    checkOutput("rst_all_empty_bridge_idle", LW'(all_empty), LW'(1));

    // Two partial stores to the same word while the bridge is stalled.
    @(posedge clk); #1;
    in_valid = 1'b1; in_type = 3'b010; in_addr = 32'h1faf0000;
    in_wstrb = 4'b0011; in_data = 128'h0000aaaa;
    @(posedge clk); #1;
    in_wstrb = 4'b1100; in_data = 128'hbbbb0000;
    @(posedge clk); #1;
    in_valid = 1'b0; wr_rdy = 1'b1;
    @(negedge clk);
    checkOutput("mrg_first_req", LW'(wr_req), LW'(1));
    checkOutput("mrg_first_wstrb", LW'(wr_wstrb), MERGE ? LW'(4'hf) : LW'(4'b0011));
    checkOutput("mrg_first_data", LW'(wr_data[31:0]), MERGE ? LW'(32'hbbbbaaaa) : LW'(32'h0000aaaa));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("mrg_second_req", LW'(wr_req), MERGE ? LW'(0) : LW'(1));

    // Random traffic over a few overlapping lines, checked by the scoreboard.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 3))
        0: rnd_type = 3'b000;
        1: rnd_type = 3'b001;
        2: rnd_type = 3'b010;
        default: rnd_type = 3'b100;
      endcase
      case ($urandom_range(0, 2))
        0: rnd_addr = 32'h1c000040;
        1: rnd_addr = (rnd_type == 3'b100) ? 32'h1c000050 : 32'h1c000044;
        default: rnd_addr = 32'h1faf0000;
      endcase
      in_valid     = ($urandom_range(0, 2) != 0);
      in_type      = rnd_type;
      in_addr      = rnd_addr;
      in_wstrb     = (rnd_type == 3'b100) ? 4'hf : 4'($urandom_range(1, 15));
      in_data      = {$urandom, $urandom, $urandom, $urandom};
      wr_rdy       = ($urandom_range(0, 2) == 0);
      bridge_empty = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: query_addr = 32'h1c000048;
        1: query_addr = 32'h1c00005c;
        2: query_addr = 32'h1faf000c;
        default: query_addr = 32'h20000000;
      endcase
    end

    @(posedge clk); #1;
    in_valid = 1'b0; wr_rdy = 1'b1; bridge_empty = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_wr_req", LW'(wr_req), LW'(0));
    checkOutput("drain_all_empty", LW'(all_empty), LW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
